// File: rtl/apb_pkg.sv
// Shared types and constants for the APB master bridge: FSM state encoding,
// command/response payloads and wait-timer sizing.
package apb_pkg;

    localparam int unsigned APB_ADDR_W = 32;
    localparam int unsigned APB_DATA_W = 32;
    localparam int unsigned APB_STRB_W = APB_DATA_W / 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                  write;
        logic [APB_ADDR_W-1:0] addr;
        logic [APB_DATA_W-1:0] wdata;
        logic [APB_STRB_W-1:0] strb;
    } apb_cmd_t;

    typedef struct packed {
        logic [APB_DATA_W-1:0] rdata;
        logic                  err;
    } apb_rsp_t;

    // Counter must be able to represent TIMEOUT_CYCLES; a disabled timeout still needs one bit.
    function automatic int unsigned timer_width(input int unsigned timeout_cycles);
        return (timeout_cycles == 0) ? 1 : $clog2(timeout_cycles + 1);
    endfunction

endpackage

// File: rtl/apb_master_bridge_if.sv
// Request/response channels plus APB bus signals of the bridge; master is the
// bridge side, slave is the side that issues commands and models the APB slave.
interface apb_master_bridge_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned NBYTES     = DATA_WIDTH / 8
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;
    logic [NBYTES-1:0]     cmd_strb;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;

    logic                  PSELx;
    logic                  PENABLE;
    logic [ADDR_WIDTH-1:0] PADDR;
    logic                  PWRITE;
    logic [DATA_WIDTH-1:0] PWDATA;
    logic [NBYTES-1:0]     PSTRB;
    logic [DATA_WIDTH-1:0] PRDATA;
    logic                  PREADY;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, PRDATA, PREADY,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        output PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata, cmd_strb, rsp_ready, PRDATA, PREADY,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
        input  PSELx, PENABLE, PADDR, PWRITE, PWDATA, PSTRB
    );

endinterface

// File: rtl/apb_wait_timer.sv
// Saturating count of ACCESS cycles with PREADY low; expired_o flags that the
// current ACCESS cycle is the last one allowed before abort.
module apb_wait_timer
    import apb_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic inc_i,
    output logic expired_o
);
    localparam int unsigned CNT_W   = timer_width(TIMEOUT_CYCLES);
    localparam int unsigned LIMIT   = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic        ENABLED = (TIMEOUT_CYCLES != 0);

    logic [CNT_W-1:0] count_q, count_d;
    logic             expired_q, expired_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (inc_i && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
        // Flag is precomputed from the next count so it is a clean register output.
        expired_d = ENABLED && (count_d == CNT_W'(LIMIT));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            count_q   <= '0;
            expired_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            expired_q <= expired_d;
        end
    end

    assign expired_o = expired_q;

endmodule

// File: rtl/apb_master_bridge.sv
// APB requester: one command at a time through SETUP/ACCESS with wait states
// and a bounded timeout, returning read data and status on a response channel.
module apb_master_bridge
    import apb_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = APB_DATA_W,
    parameter int unsigned ADDR_WIDTH     = APB_ADDR_W,
    parameter int unsigned NBYTES         = DATA_WIDTH / 8,
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic               PCLK,
    input  logic               PRESET,
    apb_master_bridge_if.master bus
);
    localparam logic [1:0] S_IDLE   = IDLE;
    localparam logic [1:0] S_SETUP  = SETUP;
    localparam logic [1:0] S_ACCESS = ACCESS;
    localparam logic [1:0] S_RESP   = RESP;

    logic [1:0] state_q, state_d;
    apb_cmd_t   cmd_q, cmd_d;
    apb_rsp_t   rsp_q, rsp_d;
    logic       psel_q, psel_d;
    logic       penable_q, penable_d;
    logic       rsp_valid_q, rsp_valid_d;

    logic       cmd_ready_c;
    logic       cmd_hs_c;
    logic       timer_clear_c;
    logic       timer_inc_c;
    logic       timer_expired;

    apb_wait_timer #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wait_timer (
        .clk_i     (PCLK),
        .rst_i     (PRESET),
        .clear_i   (timer_clear_c),
        .inc_i     (timer_inc_c),
        .expired_o (timer_expired)
    );

    // Next-state, datapath capture and registered-output decode.
    always_comb begin
        state_d       = state_q;
        cmd_d         = cmd_q;
        rsp_d         = rsp_q;
        cmd_ready_c   = 1'b0;
        timer_clear_c = 1'b0;
        timer_inc_c   = 1'b0;

        case (state_q)
            S_IDLE: begin
                cmd_ready_c = 1'b1;
            end
            S_SETUP: begin
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (bus.PREADY) begin
                    state_d   = S_RESP;
                    rsp_d.err = 1'b0;
                    rsp_d.rdata = cmd_q.write ? '0 : APB_DATA_W'(bus.PRDATA);
                end else if (timer_expired) begin
                    state_d     = S_RESP;
                    rsp_d.err   = 1'b1;
                    rsp_d.rdata = '0;
                end else begin
                    timer_inc_c = 1'b1;
                end
            end
            S_RESP: begin
                if (bus.rsp_ready) begin
                    cmd_ready_c = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        cmd_hs_c = bus.cmd_valid && cmd_ready_c;

        // Reads leave PWDATA untouched and never assert strobes.
        if (cmd_hs_c) begin
            state_d       = S_SETUP;
            timer_clear_c = 1'b1;
            cmd_d.write   = bus.cmd_write;
            cmd_d.addr    = APB_ADDR_W'(bus.cmd_addr);
            cmd_d.strb    = bus.cmd_write ? APB_STRB_W'(bus.cmd_strb) : '0;
            if (bus.cmd_write) begin
                cmd_d.wdata = APB_DATA_W'(bus.cmd_wdata);
            end
        end

        psel_d      = (state_d == S_SETUP) || (state_d == S_ACCESS);
        penable_d   = (state_d == S_ACCESS);
        rsp_valid_d = (state_d == S_RESP);
    end

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state_q     <= S_IDLE;
            cmd_q       <= '0;
            rsp_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_q       <= cmd_d;
            rsp_q       <= rsp_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.cmd_ready = cmd_ready_c;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = DATA_WIDTH'(rsp_q.rdata);
    assign bus.rsp_err   = rsp_q.err;
    assign bus.PSELx     = psel_q;
    assign bus.PENABLE   = penable_q;
    assign bus.PADDR     = ADDR_WIDTH'(cmd_q.addr);
    assign bus.PWRITE    = cmd_q.write;
    assign bus.PWDATA    = DATA_WIDTH'(cmd_q.wdata);
    assign bus.PSTRB     = NBYTES'(cmd_q.strb);

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- APB requester that sits directly upstream of the APB slave bus and drives the signals the bus protocol checker observes.
- Accepts one command at a time on a valid/ready request channel.
- Runs the APB SETUP and ACCESS phases, including wait states, and returns read data and status on a valid/ready response channel.
- Bounds slave wait states with a timeout counter.

Parameters:
- DATA_WIDTH, 32: PWDATA/PRDATA/cmd_wdata/rsp_rdata width; must be a multiple of 8.
- ADDR_WIDTH, 32: PADDR/cmd_addr width.
- NBYTES, DATA_WIDTH/8: PSTRB/cmd_strb width.
- TIMEOUT_CYCLES, 16: maximum ACCESS cycles with PREADY=0 before abort; 0 disables the timeout.

Ports:
- PCLK  in  1  sole clock; all logic on posedge.
- PRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_write  in  1  1=write, 0=read.
- cmd_addr  in  ADDR_WIDTH  transfer address.
- cmd_wdata  in  DATA_WIDTH  write data.
- cmd_strb  in  NBYTES  write byte strobes.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed.
- rsp_rdata  out  DATA_WIDTH  read data (0 for writes and timeouts).
- rsp_err  out  1  1 = transfer aborted by timeout.
- PSELx  out  1  APB select.
- PENABLE  out  1  APB enable.
- PADDR  out  ADDR_WIDTH  APB address.
- PWRITE  out  1  APB direction.
- PWDATA  out  DATA_WIDTH  APB write data.
- PSTRB  out  NBYTES  APB strobes.
- PRDATA  in  DATA_WIDTH  slave read data.
- PREADY  in  1  slave ready.

Behaviour:
- Reset (PRESET=1 at a posedge):
  - Next state is IDLE.
  - PSELx, PENABLE, PWRITE, PADDR, PWDATA, PSTRB, rsp_valid, rsp_err and rsp_rdata all become 0.
  - Timeout counter clears.
  - Reset mid-transfer drops the in-flight command silently; no response is produced.
  - Outputs are never X after the first reset edge.
- States:
  - IDLE: PSELx=0, PENABLE=0.
  - SETUP: PSELx=1, PENABLE=0.
  - ACCESS: PSELx=1, PENABLE=1.
  - RESP: PSELx=0, PENABLE=0, rsp_valid=1.
- cmd_ready is combinational: 1 in IDLE, or in RESP when rsp_ready=1. It is 0 otherwise.
- IDLE→SETUP on command handshake.
  - In the same edge, register cmd_* into PADDR, PWRITE, PWDATA and PSTRB.
  - PSTRB is forced to 0 for reads.
  - PWDATA keeps its previous value for reads.
- SETUP→ACCESS unconditionally after 1 cycle.
- ACCESS with PREADY=1 → RESP.
  - rsp_rdata captures PRDATA for reads; it is 0 for writes.
  - rsp_err=0.
- ACCESS with PREADY=0: stay in ACCESS and increment the wait counter.
  - If TIMEOUT_CYCLES≠0 and the counter reaches TIMEOUT_CYCLES-1 while PREADY=0, go to RESP with rsp_err=1 and rsp_rdata=0.
  - A PREADY=1 in that same cycle wins: normal completion, err=0.
- Stability: PADDR, PWRITE, PWDATA and PSTRB are held constant from SETUP through the final ACCESS cycle. They also hold their values through RESP and IDLE until the next handshake.
- RESP:
  - rsp_valid stays 1 and rsp_* stay stable until rsp_ready=1.
  - On rsp_ready=1 with no new command, go to IDLE.
  - On rsp_ready=1 with a new command handshake in the same cycle, go to SETUP directly.
- Latency from cmd handshake to rsp_valid is 2 + wait-state cycles. Best-case back-to-back throughput is one transfer per 3 cycles.
- Counter width is $clog2(TIMEOUT_CYCLES+1), minimum 1. It clears on every entry to SETUP.
- PENABLE only rises one cycle after PSELx rises. PENABLE always falls after the completing ACCESS cycle.

Decomposition:
- Package apb_pkg:
  - State enum apb_state_e {IDLE, SETUP, ACCESS, RESP}.
  - Packed struct apb_cmd_t {write, addr, wdata, strb}, parameterised via package localparams APB_ADDR_W=32 and APB_DATA_W=32.
  - Response struct apb_rsp_t {rdata, err}.
- Sub-module apb_wait_timer holds the saturating counter with clear/inc/expired, parameter TIMEOUT_CYCLES. The FSM and datapath stay in apb_master_bridge.

Test Plan:
- Write, no wait: cmd write addr=0x10, wdata=0xDEADBEEF, strb=0xF; PREADY tied 1 → PSELx high 2 cycles, PENABLE in cycle 2, PSTRB=0xF, rsp_valid 2 cycles after handshake, rsp_err=0, rsp_rdata=0.
- Read with 3 wait states: PREADY=0 for 3 ACCESS cycles, then 1 with PRDATA=0x12345678 → PADDR stable all 5 bus cycles, PSTRB=0, rsp_rdata=0x12345678.
- Timeout: TIMEOUT_CYCLES=4, PREADY stuck 0 → exactly 4 ACCESS cycles, then PSELx=0, rsp_err=1, rsp_rdata=0. PREADY=1 on the 4th cycle instead gives err=0.
- Back-to-back with response backpressure: hold rsp_ready=0 for 5 cycles → rsp fields stable and cmd_ready=0. Then rsp_ready=1 with cmd_valid=1 → next SETUP on the following cycle, no IDLE cycle.
- Mid-transfer reset: PRESET=1 during ACCESS → next cycle all outputs 0, no rsp_valid. A subsequent command completes normally.
- Protocol-checker bind: random 1000 commands with random PREADY delays 0–3 → zero assertion failures for stability, non-X and phase ordering.
